// File: rtl/conv2_feed_sched.sv
// conv2 line-buffer feed sequencer: streams IN_CH maps from the conv1 RAM, clears the buffer
// between channels and tags valid KxK windows. Define CONV2_FEED_SCHED_PERF_EN for cycle counters.
module conv2_feed_sched #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int IN_CH     = 3,
    parameter int K         = 5,
    parameter int ADDR_BITS = 10,
    parameter int RD_LAT    = 1,
    localparam int WR_W     = ((HEIGHT - K + 1) > 1) ? $clog2(HEIGHT - K + 1) : 1,
    localparam int WC_W     = ((WIDTH - K + 1) > 1) ? $clog2(WIDTH - K + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    input  logic                 stall_i,
    output logic                 rd_en_o,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    output logic                 buf_valid_in_o,
    output logic                 buf_rst_n_o,
    output logic                 win_valid_o,
    output logic [WR_W-1:0]      win_row_o,
    output logic [WC_W-1:0]      win_col_o,
    output logic                 win_first_ch_o,
    output logic                 win_last_ch_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef CONV2_FEED_SCHED_PERF_EN
    ,
    output logic [15:0]          stall_cycles_o,
    output logic [15:0]          pass_cycles_o
`endif
);

    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CH_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 rd_en_s;
    logic                 last_pix_s;
    logic                 pipe_empty_s;

    logic [RD_LAT-1:0]    vld_q;
    logic [ROW_W-1:0]     prow_q [RD_LAT];
    logic [COL_W-1:0]     pcol_q [RD_LAT];

    logic                 win_hit_s;
    logic                 win_valid_q;
    logic [WR_W-1:0]      win_row_q;
    logic [WC_W-1:0]      win_col_q;
    logic                 win_first_q;
    logic                 win_last_q;

    // Sequencer next-state: the read address is one running counter because channels are contiguous
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        rd_en_s      = 1'b0;
        last_pix_s   = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));
        pipe_empty_s = (vld_q == '0) && !win_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    ch_d    = '0;
                    addr_d  = base_addr_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (!stall_i) begin
                    rd_en_s = 1'b1;
                    addr_d  = addr_q + ADDR_BITS'(1);
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_pix_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                // ch_q must stay put until the last window of this channel has been tagged
                if (pipe_empty_s) begin
                    if (ch_q == CH_W'(IN_CH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
        end
    end

    // Read-latency pipe carrying pixel coordinates alongside the strobe; never frozen by stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                prow_q[i] <= '0;
                pcol_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= rd_en_s;
            prow_q[0] <= row_q;
            pcol_q[0] <= col_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prow_q[i] <= prow_q[i-1];
                pcol_q[i] <= pcol_q[i-1];
            end
        end
    end

    assign win_hit_s = vld_q[RD_LAT-1]
                     && (prow_q[RD_LAT-1] >= ROW_W'(K - 1))
                     && (pcol_q[RD_LAT-1] >= COL_W'(K - 1));

    // Window tag stage: the buffer holds a full window one cycle after the bottom-right pixel enters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else if (win_hit_s) begin
            win_valid_q <= 1'b1;
            win_row_q   <= WR_W'(prow_q[RD_LAT-1] - ROW_W'(K - 1));
            win_col_q   <= WC_W'(pcol_q[RD_LAT-1] - COL_W'(K - 1));
            win_first_q <= (ch_q == '0);
            win_last_q  <= (ch_q == CH_W'(IN_CH - 1));
        end else begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end
    end

`ifdef CONV2_FEED_SCHED_PERF_EN
    logic [15:0] stall_cyc_q;
    logic [15:0] pass_cyc_q;

    // Saturating performance counters, cleared when a pass is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cyc_q <= 16'h0000;
            pass_cyc_q  <= 16'h0000;
        end else if ((state_q == S_IDLE) && start_i) begin
            stall_cyc_q <= 16'h0000;
            pass_cyc_q  <= 16'h0000;
        end else begin
            if ((state_q == S_STREAM) && stall_i && (stall_cyc_q != 16'hFFFF)) begin
                stall_cyc_q <= stall_cyc_q + 16'd1;
            end else begin
                stall_cyc_q <= stall_cyc_q;
            end
            if ((state_q != S_IDLE) && (pass_cyc_q != 16'hFFFF)) begin
                pass_cyc_q <= pass_cyc_q + 16'd1;
            end else begin
                pass_cyc_q <= pass_cyc_q;
            end
        end
    end

    assign stall_cycles_o = stall_cyc_q;
    assign pass_cycles_o  = pass_cyc_q;
`endif

    assign rd_en_o        = rd_en_s;
    assign rd_addr_o      = addr_q;
    assign buf_valid_in_o = vld_q[RD_LAT-1];
    assign buf_rst_n_o    = (state_q != S_CLEAR);
    assign win_valid_o    = win_valid_q;
    assign win_row_o      = win_row_q;
    assign win_col_o      = win_col_q;
    assign win_first_ch_o = win_first_q;
    assign win_last_ch_o  = win_last_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);

endmodule
